// File: rtl/paddle_input_ctl.sv
// N-channel paddle input conditioner: CDC sync, tear filter, clamp and frame-locked slew for
// positions; sync, debounce and press pulse for buttons. Every channel is independent.
module paddle_input_ctl #(
  parameter int CHANNELS     = 2,
  parameter int POS_W        = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 671,
  parameter int POS_RESET    = 335,
  parameter int MAX_STEP     = 16,
  parameter int DEBOUNCE_CYC = 65000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*POS_W-1:0] pos_in,
  input  logic [CHANNELS-1:0]       btn_in,
  input  logic                      frame_tick,
  output logic [CHANNELS*POS_W-1:0] pos_out,
  output logic [CHANNELS-1:0]       pos_moving,
  output logic [CHANNELS-1:0]       btn_level,
  output logic [CHANNELS-1:0]       btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [POS_W-1:0]        MIN_V   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]        MAX_V   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]        RESET_V = POS_W'(POS_RESET);
  localparam logic [POS_W-1:0]        STEP_U  = POS_W'(MAX_STEP);
  localparam logic signed [POS_W:0]   STEP_S  = (POS_W + 1)'(MAX_STEP);
  localparam logic [CNT_W-1:0]        DEB_V   = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } btn_state_t;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch

    logic [SYNC_STAGES-1:0][POS_W-1:0] pos_sync;
    logic [POS_W-1:0]                  pos_s;
    logic [POS_W-1:0]                  s_prev;
    logic [POS_W-1:0]                  clamped;
    logic [POS_W-1:0]                  target;
    logic [POS_W-1:0]                  pos_q;
    logic signed [POS_W:0]             diff;
    logic signed [POS_W:0]             diff_abs;
    int                                s_val;

    assign pos_s = pos_sync[SYNC_STAGES-1];
    assign s_val = int'(pos_s);

    always_comb begin
      clamped = pos_s;
      if (s_val < POS_MIN) begin
        clamped = MIN_V;
      end else if (s_val > POS_MAX) begin
        clamped = MAX_V;
      end
    end

    always_comb begin
      diff     = $signed({1'b0, target}) - $signed({1'b0, pos_q});
      diff_abs = diff[POS_W] ? -diff : diff;
    end

    // A synced word is trusted only once two consecutive samples agree, so a
    // half-updated multi-bit value caught mid-transition never reaches target.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pos_sync <= '0;
        s_prev   <= '0;
        target   <= RESET_V;
      end else begin
        pos_sync <= {pos_sync[SYNC_STAGES-2:0], pos_in[k*POS_W +: POS_W]};
        s_prev   <= pos_s;
        if (pos_s == s_prev) begin
          target <= clamped;
        end
      end
    end

    // Slew never overshoots: a full step is only taken when the target is
    // further away than MAX_STEP, so the result stays inside the clamp range.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pos_q <= RESET_V;
      end else if (frame_tick) begin
        if (MAX_STEP == 0 || diff_abs <= STEP_S) begin
          pos_q <= target;
        end else if (!diff[POS_W]) begin
          pos_q <= pos_q + STEP_U;
        end else begin
          pos_q <= pos_q - STEP_U;
        end
      end
    end

    assign pos_out[k*POS_W +: POS_W] = pos_q;
    assign pos_moving[k]             = (pos_q != target);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   btn_s;
    btn_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic                   level_q;
    logic                   press_q;

    assign btn_s = btn_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        btn_sync <= '0;
      end else begin
        btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_in[k]};
      end
    end

    // Counter stops at DEBOUNCE_CYC because the state always leaves WAIT_* there.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= IDLE_LO;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        case (state)
          IDLE_LO: begin
            if (btn_s) begin
              state <= WAIT_HI;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_HI: begin
            if (!btn_s) begin
              state <= IDLE_LO;
            end else if (cnt == DEB_V) begin
              state   <= IDLE_HI;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE_HI: begin
            if (!btn_s) begin
              state <= WAIT_LO;
              cnt   <= CNT_ONE;
            end
          end
          WAIT_LO: begin
            if (btn_s) begin
              state <= IDLE_HI;
            end else if (cnt == DEB_V) begin
              state   <= IDLE_LO;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE_LO;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[k] = level_q;
    assign btn_press[k] = press_q;

  end : g_ch

endmodule
